// File: rtl/cache_controller.sv
// cache_controller
//   Per-cache control FSM in front of the cache sets. It decodes processor
//   read/write requests against the set hit/dirty status and drives the
//   5-bit set control word. On a miss it writes a dirty victim line back
//   word by word, then refills the line from memory. The processor stalls
//   (ready_o=0) until the held request can complete as a hit.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   read_en_i         processor read request
//   write_en_i        processor write request (wins if both are asserted)
//   addr_i[31:0]      processor address, held while ready_o=0
//   hit_i             OR of the set hit lines
//   dirty_i           dirty bit of the selected line (hit line, else victim)
//   tag_i             tag of the selected line (victim tag on a miss)
//   mem_ready_i       memory finished the current word transfer this cycle
//   control_o[4:0]    {write_en, set_valid, set_dirty, strategy_en, offset_sel}
//   mem_addr_o[31:0]  memory word address, also the set's refill offset source
//   mem_read_en_o     memory read request
//   mem_write_en_o    memory write request
//   ready_o           request completes this cycle
module cache_controller #(
  parameter int unsigned TAG_WIDTH    = 26,
  parameter int unsigned SET_WIDTH    = 2,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 read_en_i,
  input  logic                 write_en_i,
  input  logic [31:0]          addr_i,
  input  logic                 hit_i,
  input  logic                 dirty_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 mem_ready_i,
  output logic [4:0]           control_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_read_en_o,
  output logic                 mem_write_en_o,
  output logic                 ready_o
);

  localparam int unsigned CW = OFFSET_WIDTH - 2;

  localparam logic [4:0] CTRL_NONE      = 5'b00000;
  localparam logic [4:0] CTRL_READ_HIT  = 5'b00011;
  localparam logic [4:0] CTRL_WRITE_HIT = 5'b11111;
  localparam logic [4:0] CTRL_FILL_WORD = 5'b10000;
  localparam logic [4:0] CTRL_FILL_LAST = 5'b11000;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    ALLOCATE
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, next_cnt;
  logic            req;
  logic            cnt_last;
  logic [SET_WIDTH-1:0] set_idx;

  assign req      = read_en_i | write_en_i;
  assign cnt_last = &cnt;
  assign set_idx  = addr_i[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH];

  // State and word counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (req && !hit_i) begin
          next_cnt   = '0;
          next_state = dirty_i ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (mem_ready_i) begin
          if (cnt_last) begin
            next_cnt   = '0;
            next_state = ALLOCATE;
          end else begin
            next_cnt = cnt + CW'(1);
          end
        end
      end
      ALLOCATE: begin
        if (mem_ready_i) begin
          if (cnt_last) begin
            next_cnt   = '0;
            next_state = IDLE;
          end else begin
            next_cnt = cnt + CW'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    control_o      = CTRL_NONE;
    mem_addr_o     = {addr_i[31:2], 2'b00};
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    ready_o        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!req) begin
          ready_o = 1'b1;
        end else if (hit_i) begin
          ready_o   = 1'b1;
          control_o = write_en_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
        end
      end
      WRITE_BACK: begin
        // offset_sel=0 makes the set read victim word cnt for the write data
        mem_write_en_o = 1'b1;
        mem_addr_o     = {tag_i, set_idx, cnt, 2'b00};
      end
      ALLOCATE: begin
        mem_read_en_o = 1'b1;
        mem_addr_o    = {addr_i[31:OFFSET_WIDTH], cnt, 2'b00};
        if (mem_ready_i) begin
          control_o = cnt_last ? CTRL_FILL_LAST : CTRL_FILL_WORD;
        end
      end
      default: begin
        control_o = CTRL_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  localparam int unsigned TW = 26;
  localparam int unsigned SW = 2;
  localparam int unsigned OW = 4;
  localparam int unsigned NW = 4;
  localparam int unsigned NSETS = 4;
  localparam int unsigned BUDGET = 200;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          read_en_i = 1'b0;
  logic          write_en_i = 1'b0;
  logic [31:0]   addr_i = '0;
  logic          hit_i = 1'b0;
  logic          dirty_i = 1'b0;
  logic [TW-1:0] tag_i = '0;
  logic          mem_ready_i = 1'b0;
  logic [4:0]    control_o;
  logic [31:0]   mem_addr_o;
  logic          mem_read_en_o;
  logic          mem_write_en_o;
  logic          ready_o;

  int tests = 0;
  int fails = 0;

  cache_controller #(
    .TAG_WIDTH(TW),
    .SET_WIDTH(SW),
    .OFFSET_WIDTH(OW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .read_en_i(read_en_i),
    .write_en_i(write_en_i),
    .addr_i(addr_i),
    .hit_i(hit_i),
    .dirty_i(dirty_i),
    .tag_i(tag_i),
    .mem_ready_i(mem_ready_i),
    .control_o(control_o),
    .mem_addr_o(mem_addr_o),
    .mem_read_en_o(mem_read_en_o),
    .mem_write_en_o(mem_write_en_o),
    .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Direct-mapped cache contents as seen by the sets
  logic          c_valid [NSETS];
  logic          c_dirty [NSETS];
  logic [TW-1:0] c_tag   [NSETS];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
  } xfer_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_status();
    int unsigned s;
    s       = int'(addr_i[OW+SW-1:OW]);
    hit_i   = c_valid[s] && (c_tag[s] == addr_i[31:OW+SW]);
    dirty_i = c_valid[s] && c_dirty[s];
    tag_i   = c_tag[s];
  endtask

  // One hit cycle of the held request; call with inputs applied, before the negedge
  task automatic hit_cycle(input logic [31:0] a, input logic rd, input logic wr);
    drive_status();
    mem_ready_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    check("hit_ready", 32'(ready_o), 32'(1));
    check("hit_ctrl", 32'(control_o), wr ? 32'h1F : 32'h03);
    check("hit_mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    check("hit_addr", mem_addr_o, {a[31:2], 2'b00});
    @(posedge clk_i);
    if (wr) c_dirty[int'(a[OW+SW-1:OW])] = 1'b1;
    #1;
  endtask

  // Full request: mode 0 = mem_ready always 1, 1 = toggles 0,1, 2 = random
  task automatic do_request(input logic [31:0] a, input logic rd, input logic wr,
                            input int mode, output int cycles);
    xfer_t q[$];
    xfer_t x;
    int    phase;
    logic  mr;
    logic [31:0] exp_ctrl;
    int unsigned s;
    addr_i     = a;
    read_en_i  = rd;
    write_en_i = wr;
    cycles     = 0;
    s          = int'(a[OW+SW-1:OW]);
    drive_status();
    if (!rd && !wr) begin
      mem_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      check("idle_ready", 32'(ready_o), 32'(1));
      check("idle_ctrl", 32'(control_o), 32'd0);
      check("idle_mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
      @(posedge clk_i); #1;
      cycles = 1;
      return;
    end
    if (hit_i) begin
      hit_cycle(a, rd, wr);
      cycles = 1;
      return;
    end
    // Miss: expected memory transfers, victim write-back first
    if (dirty_i)
      for (int i = 0; i < int'(NW); i++) begin
        x.wr   = 1'b1;
        x.addr = {c_tag[s], a[OW+SW-1:OW], 4'(i * 4)};
        q.push_back(x);
      end
    for (int i = 0; i < int'(NW); i++) begin
      x.wr   = 1'b0;
      x.addr = {a[31:OW], 4'(i * 4)};
      q.push_back(x);
    end
    mem_ready_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    check("miss_ready", 32'(ready_o), 32'd0);
    check("miss_ctrl", 32'(control_o), 32'd0);
    check("miss_mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    @(posedge clk_i); #1;
    cycles = 1;
    phase  = 0;
    while (q.size() > 0 && cycles < int'(BUDGET)) begin
      case (mode)
        0:       mr = 1'b1;
        1:       mr = 1'(phase % 2);
        default: mr = 1'($urandom_range(0, 1));
      endcase
      phase++;
      mem_ready_i = mr;
      @(negedge clk_i);
      x = q[0];
      if (!x.wr && mr) exp_ctrl = (q.size() == 1) ? 32'h18 : 32'h10;
      else             exp_ctrl = 32'h00;
      check("xfer_addr", mem_addr_o, x.addr);
      check("xfer_wen", 32'(mem_write_en_o), 32'(x.wr));
      check("xfer_ren", 32'(mem_read_en_o), 32'(!x.wr));
      check("xfer_ctrl", 32'(control_o), exp_ctrl);
      check("xfer_ready", 32'(ready_o), 32'd0);
      @(posedge clk_i); #1;
      cycles++;
      if (mr) void'(q.pop_front());
    end
    check("xfer_budget_left", 32'(q.size()), 32'd0);
    c_valid[s] = 1'b1;
    c_dirty[s] = 1'b0;
    c_tag[s]   = a[31:OW+SW];
    hit_cycle(a, rd, wr);
    cycles++;
  endtask

  initial begin
    int cyc;
    logic [31:0] a;
    logic rd, wr;
    for (int i = 0; i < int'(NSETS); i++) begin
      c_valid[i] = 1'b0;
      c_dirty[i] = 1'b0;
      c_tag[i]   = '0;
    end

    // Reset state
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_ready", 32'(ready_o), 32'(1));
    check("reset_ctrl", 32'(control_o), 32'd0);
    check("reset_mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    @(posedge clk_i); #1;

    // Read hit, zero stall
    c_valid[0] = 1'b1;
    c_tag[0]   = 26'h10;
    do_request(32'h0000_0404, 1'b1, 1'b0, 0, cyc);
    check("read_hit_cycles", 32'(cyc), 32'd1);

    // Clean read miss: 1 + 4 + 1 cycles
    do_request(32'h0000_1234, 1'b1, 1'b0, 0, cyc);
    check("clean_miss_cycles", 32'(cyc), 32'd6);

    // Dirty write miss: victim tag 0xAB in set 3
    c_valid[3] = 1'b1;
    c_dirty[3] = 1'b1;
    c_tag[3]   = 26'h0AB;
    do_request(32'h0000_1234, 1'b0, 1'b1, 0, cyc);
    check("dirty_miss_cycles", 32'(cyc), 32'd10);

    // Dirty miss with alternating wait states: 1 + 8 + 8 + 1
    do_request(32'h0000_2234, 1'b1, 1'b0, 1, cyc);
    check("wait_miss_cycles", 32'(cyc), 32'd18);

    // Read and write together on a hit behave as a write
    do_request(32'h0000_2238, 1'b1, 1'b1, 2, cyc);
    check("rdwr_hit_cycles", 32'(cyc), 32'd1);

    // Reset in ALLOCATE at cnt=2
    addr_i     = 32'h0000_0020;
    read_en_i  = 1'b1;
    write_en_i = 1'b0;
    drive_status();
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    check("alloc_cnt2_addr", mem_addr_o, 32'h0000_0028);
    check("alloc_cnt2_ren", 32'(mem_read_en_o), 32'(1));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    read_en_i = 1'b0;
    @(negedge clk_i);
    check("midrst_ready", 32'(ready_o), 32'(1));
    check("midrst_ctrl", 32'(control_o), 32'd0);
    check("midrst_mem_en", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    @(posedge clk_i); #1;
    // Line stayed invalid; the refill restarts from word 0
    do_request(32'h0000_0020, 1'b1, 1'b0, 0, cyc);
    check("post_rst_miss_cycles", 32'(cyc), 32'd6);

    // Randomized traffic over a small tag pool
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0:       a[31:OW+SW] = 26'h48;
        1:       a[31:OW+SW] = 26'h88;
        default: a[31:OW+SW] = 26'(3 + $urandom_range(0, 1));
      endcase
      a[OW+SW-1:0] = 6'($urandom);
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      do_request(a, rd, wr, int'($urandom_range(0, 2)), cyc);
    end

    read_en_i  = 1'b0;
    write_en_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
